// File: rtl/main_fsm.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and ALUOp, and counts retired instructions.
// Optional MAIN_FSM_TRAP_EN: unknown opcodes park the FSM in TRAP and raise illegal.
module main_fsm #(
  parameter int RET_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             memReady,
  output logic             memReq,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [RET_W-1:0] retCnt,
  output logic             illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_JAL,
    S_BEQ
`ifdef MAIN_FSM_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t state;
  state_t state_next;
  logic   retire;

  // Memory handshake: memReq stays high for the whole access; the access
  // completes (and the FSM moves on) on the first edge where memReady is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      retCnt <= '0;
    end else begin
      state <= state_next;
      if (retire) retCnt <= retCnt + RET_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_FETCH:    if (memReady) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
`ifdef MAIN_FSM_TRAP_EN
          default:      state_next = S_TRAP;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (memReady) state_next = S_MEMWB;
      S_MEMWB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        if (memReady) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_JAL:      state_next = S_ALUWB;
      S_BEQ: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
`ifdef MAIN_FSM_TRAP_EN
      S_TRAP:     state_next = S_TRAP;
`endif
      default:    state_next = S_FETCH;
    endcase
  end

  // Moore decode; only the FETCH write enables also wait on memReady.
  always_comb begin
    memReq    = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state)
      S_FETCH: begin
        memReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = memReady;
        PCUpdate  = memReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        memReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        memReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MAIN_FSM_TRAP_EN
  // TRAP is only left by reset, so this is sticky until reset.
  assign illegal = (state == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule
